da_scheduler: RTL

Front-end sequencer for the distributed-arithmetic FIR datapath controller. It streams the precomputed lookup-ROM contents into the coefficient SRAM and generates the addresses and active-low strobes. It then buffers incoming samples in a small FIFO and issues one start pulse per sample to the DA controller, waiting for that controller's valid_out before issuing the next. This decouples the upstream sample stream from the multi-cycle DA evaluation.

---
 rtl/da_pkg.sv | 26 ++
 rtl/da_sample_fifo.sv | 59 +++++
 rtl/da_scheduler.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/da_pkg.sv
// Shared definitions for the DA FIR front-end: scheduler state encoding,
// active-low SRAM strobe levels and default datapath sizes.
package da_pkg;

    // Default sizes used by the scheduler and its sample FIFO
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ROM_AW   = 4;
    localparam int DEF_FIFO_AW  = 2;
    localparam int DEF_WD_LIMIT = 15;

    // Scheduler state encoding
    localparam logic [1:0] ST_LOAD_ENC = 2'd0;
    localparam logic [1:0] ST_IDLE_ENC = 2'd1;
    localparam logic [1:0] ST_WAIT_ENC = 2'd2;

    typedef enum logic [1:0] {
        ST_LOAD = ST_LOAD_ENC,
        ST_IDLE = ST_IDLE_ENC,
        ST_WAIT = ST_WAIT_ENC
    } state_t;

    // Active-low SRAM strobe levels, shared with the DA controller
    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

endpackage

// File: rtl/da_sample_fifo.sv
// Small synchronous sample FIFO: head-of-queue visible combinationally,
// occupancy counter, full/empty flags, async active-low reset of control state.
module da_sample_fifo #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [AW:0]   o_count
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
    always_ff @(posedge clk or negedge resetn) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sample storage write port
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/da_scheduler.sv
// DA FIR front-end sequencer: streams the lookup-ROM image into the
// coefficient SRAM, then buffers samples and issues one da_start per sample,
// waiting for the DA controller's da_valid_out between evaluations.
// Optional feature macro DA_WATCHDOG_EN: bounds the WAIT state with a cycle
// watchdog that raises a sticky wd_err and abandons the stuck evaluation.
module da_scheduler
    import da_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ROM_AW  = DEF_ROM_AW,
    parameter int FIFO_AW = DEF_FIFO_AW
`ifdef DA_WATCHDOG_EN
    ,
    parameter int WD_LIMIT = DEF_WD_LIMIT
`endif
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_cload,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic [ROM_AW-1:0] o_rom_addr,
    output logic [DATA_W-1:0] o_rom_din,
    output logic              o_rom_cen,
    output logic              o_rom_wen,
    output logic              o_load_done,
    output logic              o_da_start,
    output logic [DATA_W-1:0] o_da_sample,
    input  logic              i_da_valid_out,
    output logic              o_busy,
    output logic              o_wd_err
);

    state_t              r_state;
    state_t              w_next_state;

    logic [ROM_AW-1:0]   r_wr_idx;
    logic                r_load_done;
    logic [ROM_AW-1:0]   r_rom_addr;
    logic [DATA_W-1:0]   r_rom_din;
    logic                r_rom_cen;
    logic                r_rom_wen;
    logic                r_da_start;
    logic [DATA_W-1:0]   r_da_sample;

    logic                w_in_ready;
    logic                w_load_xfer;
    logic                w_push;
    logic                w_pop;
    logic                w_reload;
    logic                w_wd_timeout;

    logic [DATA_W-1:0]   w_fifo_head;
    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic [FIFO_AW:0]    w_fifo_count;

    da_sample_fifo #(
        .DW (DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (i_in_data),
        .o_head  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_LOAD;
        else         r_state <= w_next_state;
    end

    // Next-state logic: pending samples take priority over a reload request
    always_comb begin
        // NOTE: assign a default first so every path drives the signal and no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_LOAD: if (w_load_xfer && (&r_wr_idx)) w_next_state = ST_IDLE;
            ST_IDLE: begin
                if (!w_fifo_empty) w_next_state = ST_WAIT;
                else if (i_cload)  w_next_state = ST_LOAD;
            end
            ST_WAIT: if (i_da_valid_out || w_wd_timeout) w_next_state = ST_IDLE;
            default: w_next_state = ST_LOAD;
        endcase
    end

    // Handshake and datapath control decoded from the current state
    always_comb begin
        w_in_ready  = 1'b0;
        w_load_xfer = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_reload    = 1'b0;
        case (r_state)
            ST_LOAD: begin
                w_in_ready  = i_cload;
                w_load_xfer = i_cload & i_in_valid;
            end
            ST_IDLE: begin
                w_in_ready = r_load_done & ~i_cload & ~w_fifo_full;
                w_push     = i_in_valid & w_in_ready;
                w_pop      = ~w_fifo_empty;
                w_reload   = w_fifo_empty & i_cload;
            end
            ST_WAIT: begin
                w_in_ready = r_load_done & ~i_cload & ~w_fifo_full;
                w_push     = i_in_valid & w_in_ready;
            end
            default: ;
        endcase
    end

    // Registered SRAM write port, load bookkeeping and DA start/sample
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_idx    <= '0;
            r_load_done <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_din   <= '0;
            r_rom_cen   <= STROBE_OFF;
            r_rom_wen   <= STROBE_OFF;
            r_da_start  <= 1'b0;
            r_da_sample <= '0;
        end else begin
            r_rom_cen  <= STROBE_OFF;
            r_rom_wen  <= STROBE_OFF;
            r_da_start <= 1'b0;
            if (w_load_xfer) begin
                r_rom_cen  <= STROBE_ON;
                r_rom_wen  <= STROBE_ON;
                r_rom_addr <= r_wr_idx;
                r_rom_din  <= i_in_data;
                r_wr_idx   <= r_wr_idx + 1'b1;
                if (&r_wr_idx) r_load_done <= 1'b1;
            end
            if (w_pop) begin
                r_da_sample <= w_fifo_head;
                r_da_start  <= 1'b1;
            end
            if (w_reload) begin
                r_load_done <= 1'b0;
                r_wr_idx    <= '0;
            end
        end
    end

`ifdef DA_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);

    logic [WD_W-1:0] r_wd_cnt;
    logic            r_wd_err;

    assign w_wd_timeout = (r_state == ST_WAIT) && !i_da_valid_out &&
                          (r_wd_cnt == WD_W'(WD_LIMIT - 1));

    // Count cycles spent in WAIT; a timeout latches a sticky error
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wd_cnt <= '0;
            r_wd_err <= 1'b0;
        end else begin
            if (r_state != ST_WAIT) r_wd_cnt <= '0;
            else if (!i_da_valid_out) r_wd_cnt <= r_wd_cnt + 1'b1;
            if (w_wd_timeout) r_wd_err <= 1'b1;
        end
    end

    assign o_wd_err = r_wd_err;
`else
    assign w_wd_timeout = 1'b0;
    assign o_wd_err     = 1'b0;
`endif

    assign o_in_ready  = w_in_ready;
    assign o_rom_addr  = r_rom_addr;
    assign o_rom_din   = r_rom_din;
    assign o_rom_cen   = r_rom_cen;
    assign o_rom_wen   = r_rom_wen;
    assign o_load_done = r_load_done;
    assign o_da_start  = r_da_start;
    assign o_da_sample = r_da_sample;
    assign o_busy      = (r_state != ST_IDLE) || (w_fifo_count != '0);

endmodule
